// File: rtl/sys_devices_pkg.sv
// Shared definitions for the sys address-space peripheral block.
//  - sys_reg_e     : word offset of each register inside the 8-word map
//  - CTRL_* / STAT_*: bit positions inside CTRL and STATUS
//  - SYS_MISS_DATA : pattern returned by a strobed read that misses the map
//  - sys_status_word(): packs the STATUS register image
package sys_devices_pkg;

  typedef enum logic [2:0] {
    SYS_ID         = 3'd0,
    SYS_CYCLES     = 3'd1,
    SYS_TMR_RELOAD = 3'd2,
    SYS_TMR_COUNT  = 3'd3,
    SYS_CTRL       = 3'd4,
    SYS_STATUS     = 3'd5,
    SYS_FIFO_DATA  = 3'd6,
    SYS_RSVD       = 3'd7
  } sys_reg_e;

  localparam int CTRL_TMR_EN   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int STAT_TMR_PEND = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_OVF      = 3;

  localparam logic [31:0] SYS_MAP_WORDS = 32'd8;
  localparam logic [31:0] SYS_MISS_DATA = 32'hAAAA_AAAA;

  // STATUS image: [0] pend, [1] empty, [2] full, [3] ovf, [7:4] fifo count
  function automatic logic [31:0] sys_status_word(input logic       pend,
                                                  input logic       empty,
                                                  input logic       full,
                                                  input logic       ovf,
                                                  input logic [3:0] cnt);
    return {24'd0, cnt, ovf, full, empty, pend};
  endfunction

endpackage

// File: rtl/sys_devices_if.sv
// Bus between the memory-op stage / FIFO consumer (master) and sys_devices (slave).
//  sys_w/sys_w_addr/sys_w_line : write strobe, word address, data
//  sys_r/sys_r_addr/sys_r_line : read strobe, word address, combinational data
//  out_valid/out_data/out_ready: FIFO head valid/ready stream
//  irq                         : timer interrupt
interface sys_devices_if;
  logic        sys_w;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_w_line;
  logic        sys_r;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_r_line;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        irq;

  modport master (
    output sys_w, sys_w_addr, sys_w_line, sys_r, sys_r_addr, out_ready,
    input  sys_r_line, out_valid, out_data, irq
  );

  modport slave (
    input  sys_w, sys_w_addr, sys_w_line, sys_r, sys_r_addr, out_ready,
    output sys_r_line, out_valid, out_data, irq
  );
endinterface

// File: rtl/sys_devices_fifo.sv
// Word FIFO feeding the out_valid/out_ready stream.
//  i_clk, i_rst : clock, async active-high reset (empties the FIFO)
//  i_push/i_data: write request; dropped when full unless a pop happens the same edge
//  i_pop        : remove head (caller only pops when non-empty)
//  o_full/o_empty/o_count: occupancy, derived from the count register
//  o_head       : head word, zero while empty
module sys_devices_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_head    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign w_push_ok = i_push & (~o_full | i_pop);

  // storage array, no reset needed: entries are only visible through the count
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sys_devices.sv
// Responder for the sys address space: ID, free-running cycle counter,
// reload timer with IRQ, and a word FIFO draining to a valid/ready consumer.
//  i_clk  : clock, all state updates on posedge
//  i_rst  : asynchronous active-high reset
//  io_bus : sys_devices_if slave (read/write strobes, read data, FIFO stream, irq)
// Read data is combinational from the current request and register state, so a
// read issued together with a write returns the pre-write value.
module sys_devices
  import sys_devices_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_0100,
  parameter logic [31:0] ID_VALUE   = 32'hC0DE_0032,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sys_devices_if.slave   io_bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_cycles;
  logic [31:0]   r_tmr_reload;
  logic [31:0]   r_tmr_count;
  logic [1:0]    r_ctrl;
  logic          r_tmr_pend;
  logic          r_ovf;

  logic [31:0]   w_w_off;
  logic [31:0]   w_r_off;
  logic          w_w_hit;
  logic          w_r_hit;
  sys_reg_e      w_w_reg;
  sys_reg_e      w_r_reg;
  logic          w_wr_reload;
  logic          w_wr_ctrl;
  logic          w_wr_status;
  logic          w_wr_fifo;
  logic          w_tmr_start;
  logic          w_tmr_expire;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_head;
  logic [31:0]   w_rdata;

  // unsigned offset: addresses below BASE wrap to huge values and miss
  assign w_w_off = io_bus.sys_w_addr - BASE;
  assign w_r_off = io_bus.sys_r_addr - BASE;
  assign w_w_hit = (w_w_off < SYS_MAP_WORDS);
  assign w_r_hit = (w_r_off < SYS_MAP_WORDS);
  assign w_w_reg = sys_reg_e'(w_w_off[2:0]);
  assign w_r_reg = sys_reg_e'(w_r_off[2:0]);

  assign w_wr_reload = io_bus.sys_w & w_w_hit & (w_w_reg == SYS_TMR_RELOAD);
  assign w_wr_ctrl   = io_bus.sys_w & w_w_hit & (w_w_reg == SYS_CTRL);
  assign w_wr_status = io_bus.sys_w & w_w_hit & (w_w_reg == SYS_STATUS);
  assign w_wr_fifo   = io_bus.sys_w & w_w_hit & (w_w_reg == SYS_FIFO_DATA);

  // enabling edge loads the count; otherwise an enabled timer at zero reloads and flags
  assign w_tmr_start  = w_wr_ctrl & io_bus.sys_w_line[CTRL_TMR_EN] & ~r_ctrl[CTRL_TMR_EN];
  assign w_tmr_expire = ~w_tmr_start & r_ctrl[CTRL_TMR_EN] & (r_tmr_count == 32'd0);

  assign w_pop = ~w_empty & io_bus.out_ready;

  sys_devices_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_wr_fifo),
    .i_pop   (w_pop),
    .i_data  (io_bus.sys_w_line),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign io_bus.out_valid  = ~w_empty;
  assign io_bus.out_data   = w_head;
  assign io_bus.irq        = r_tmr_pend & r_ctrl[CTRL_IRQ_EN];
  assign io_bus.sys_r_line = w_rdata;

  // free-running cycle counter, wraps at 2^32
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cycles <= 32'd0;
    else       r_cycles <= r_cycles + 32'd1;
  end

  // writable configuration: reload value and control bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr_reload <= 32'd0;
      r_ctrl       <= 2'd0;
    end else begin
      if (w_wr_reload) r_tmr_reload <= io_bus.sys_w_line;
      if (w_wr_ctrl)   r_ctrl       <= io_bus.sys_w_line[1:0];
    end
  end

  // timer count; decisions use the enable as it stood before this edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr_count <= 32'd0;
    end else if (w_tmr_start || w_tmr_expire) begin
      r_tmr_count <= r_tmr_reload;
    end else if (r_ctrl[CTRL_TMR_EN]) begin
      r_tmr_count <= r_tmr_count - 32'd1;
    end else begin
      r_tmr_count <= r_tmr_count;
    end
  end

  // sticky flags: a set event on the same edge as a write-1-to-clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_tmr_expire)
        r_tmr_pend <= 1'b1;
      else if (w_wr_status && io_bus.sys_w_line[STAT_TMR_PEND])
        r_tmr_pend <= 1'b0;
      if (w_wr_fifo && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_wr_status && io_bus.sys_w_line[STAT_OVF])
        r_ovf <= 1'b0;
    end
  end

  // read mux; no read side effects
  always_comb begin
    w_rdata = 32'd0;
    if (!io_bus.sys_r) begin
      w_rdata = 32'd0;
    end else if (!w_r_hit) begin
      w_rdata = SYS_MISS_DATA;
    end else begin
      case (w_r_reg)
        SYS_ID:         w_rdata = ID_VALUE;
        SYS_CYCLES:     w_rdata = r_cycles;
        SYS_TMR_RELOAD: w_rdata = r_tmr_reload;
        SYS_TMR_COUNT:  w_rdata = r_tmr_count;
        SYS_CTRL:       w_rdata = {30'd0, r_ctrl};
        // count field is 4 bits wide; a 16-deep FIFO reports full via bit 2
        SYS_STATUS:     w_rdata = sys_status_word(r_tmr_pend, w_empty, w_full, r_ovf, 4'(w_count));
        SYS_FIFO_DATA:  w_rdata = 32'(w_count);
        default:        w_rdata = 32'd0;
      endcase
    end
  end
endmodule
